// File: rtl/address_config_pkg.sv
// Shared definitions for the address-configuration write arbiter.
// Contents:
//   state_t        - control FSM states (idle, clearing PO entries, clearing DO)
//   addr_in_range  - true when a write address hits a PO entry or the DO slot
package address_config_pkg;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_CLEAR_PO = 2'd1,
      ST_CLEAR_DO = 2'd2
   } state_t;

   // All operands are zero-extended to 32 bits by the caller so one function
   // serves every address width. The lower-bound test comes first so the
   // subtraction below can never wrap.
   function automatic logic addr_in_range(input logic [31:0] addr,
                                          input logic [31:0] po_base,
                                          input logic [31:0] po_count,
                                          input logic [31:0] do_addr);
      return ((addr >= po_base) && ((addr - po_base) < po_count)) ||
             (addr == do_addr);
   endfunction

endpackage

// File: rtl/arbiter_rr_2.sv
// Two-way round-robin grant with a one-bit "last granted" pointer.
// Ports:
//   clock, reset_n - clock and async active-low reset
//   enable_i       - grants may be issued this cycle
//   req_i[1:0]     - request vector (bit 0 = req0, bit 1 = req1)
//   grant_o[1:0]   - one-hot (or zero) grant, combinational
// A grant is always taken by its requester (the grant only goes to a valid
// request), so the pointer moves whenever a grant is issued.
module arbiter_rr_2 (
   input  logic       clock,
   input  logic       reset_n,
   input  logic       enable_i,
   input  logic [1:0] req_i,
   output logic [1:0] grant_o
);

   // last_q = 1 means req1 was granted last, so req0 wins the next tie.
   logic last_q;
   logic last_d;

   always_comb begin
      grant_o = 2'b00;
      if (enable_i) begin
         case (req_i)
            2'b01:   grant_o = 2'b01;
            2'b10:   grant_o = 2'b10;
            2'b11:   grant_o = last_q ? 2'b01 : 2'b10;
            default: grant_o = 2'b00;
         endcase
      end
   end

   always_comb begin
      last_d = last_q;
      if (grant_o[0]) last_d = 1'b0;
      if (grant_o[1]) last_d = 1'b1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) last_q <= 1'b1;
      else          last_q <= last_d;
   end

endmodule

// File: rtl/address_config_arbiter.sv
// Arbitrates host (req0) and thread-side (req1) configuration writes into the
// Address Module write port and runs a bulk clear of all PO entries plus the
// Default Offset slot.
// Ports:
//   clock, reset_n             - clock and async active-low reset
//   req0_* / req1_*            - valid/ready request channels (addr, data)
//   clear_start / clear_busy   - bulk-clear trigger and in-progress flag
//   stall                      - datapath cannot take a write this cycle
//   wr_en / wr_addr / wr_data  - registered write port (latency 1)
//   addr_err                   - one-cycle pulse for a dropped out-of-range request
//   dbg_state                  - current FSM state
//
// Handshake: reqN_ready is combinational and high only for the requester the
// round-robin arbiter grants in IDLE with stall low and no clear_start; a
// transfer happens in a cycle where reqN_valid and reqN_ready are both 1.
// Valid must not depend on ready.
module address_config_arbiter
   import address_config_pkg::*;
#(
   parameter int          WRITE_ADDR_WIDTH = 10,
   parameter int          WRITE_WORD_WIDTH = 36,
   parameter int unsigned PO_ADDR_BASE     = 0,
   parameter int unsigned PO_ENTRY_COUNT   = 4,
   parameter int unsigned DO_ADDR          = 0
) (
   input  logic                        clock,
   input  logic                        reset_n,
   input  logic                        req0_valid,
   output logic                        req0_ready,
   input  logic [WRITE_ADDR_WIDTH-1:0] req0_addr,
   input  logic [WRITE_WORD_WIDTH-1:0] req0_data,
   input  logic                        req1_valid,
   output logic                        req1_ready,
   input  logic [WRITE_ADDR_WIDTH-1:0] req1_addr,
   input  logic [WRITE_WORD_WIDTH-1:0] req1_data,
   input  logic                        clear_start,
   output logic                        clear_busy,
   input  logic                        stall,
   output logic                        wr_en,
   output logic [WRITE_ADDR_WIDTH-1:0] wr_addr,
   output logic [WRITE_WORD_WIDTH-1:0] wr_data,
   output logic                        addr_err,
   output state_t                      dbg_state
);

   localparam int CW = $clog2(PO_ENTRY_COUNT);

   state_t                      state_q, state_d;
   logic [CW-1:0]               count_q, count_d;
   logic                        wr_en_q, wr_en_d;
   logic [WRITE_ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
   logic [WRITE_WORD_WIDTH-1:0] wr_data_q, wr_data_d;
   logic                        addr_err_q, addr_err_d;

   logic                        arb_enable;
   logic [1:0]                  grant;
   logic [WRITE_ADDR_WIDTH-1:0] sel_addr;
   logic [WRITE_WORD_WIDTH-1:0] sel_data;

   arbiter_rr_2 u_arb (
      .clock    (clock),
      .reset_n  (reset_n),
      .enable_i (arb_enable),
      .req_i    ({req1_valid, req0_valid}),
      .grant_o  (grant)
   );

   assign sel_addr = grant[1] ? req1_addr : req0_addr;
   assign sel_data = grant[1] ? req1_data : req0_data;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      wr_en_d    = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      addr_err_d = 1'b0;
      arb_enable = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (!stall) begin
               if (clear_start) begin
                  state_d = ST_CLEAR_PO;
                  count_d = '0;
               end else begin
                  arb_enable = 1'b1;
                  if (grant != 2'b00) begin
                     // Out-of-range requests are still consumed so the
                     // requester never blocks; they only raise addr_err.
                     if (addr_in_range(32'(sel_addr), 32'(PO_ADDR_BASE),
                                       32'(PO_ENTRY_COUNT), 32'(DO_ADDR))) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = sel_addr;
                        wr_data_d = sel_data;
                     end else begin
                        addr_err_d = 1'b1;
                     end
                  end
               end
            end
         end
         ST_CLEAR_PO: begin
            if (!stall) begin
               wr_en_d   = 1'b1;
               wr_addr_d = WRITE_ADDR_WIDTH'(PO_ADDR_BASE) + WRITE_ADDR_WIDTH'(count_q);
               wr_data_d = '0;
               if (count_q == CW'(PO_ENTRY_COUNT - 1)) begin
                  state_d = ST_CLEAR_DO;
                  count_d = '0;
               end else begin
                  count_d = count_q + CW'(1);
               end
            end
         end
         ST_CLEAR_DO: begin
            if (!stall) begin
               wr_en_d   = 1'b1;
               wr_addr_d = WRITE_ADDR_WIDTH'(DO_ADDR);
               wr_data_d = '0;
               state_d   = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            count_d = '0;
         end
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         count_q    <= '0;
         wr_en_q    <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         addr_err_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         wr_en_q    <= wr_en_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         addr_err_q <= addr_err_d;
      end
   end

   assign req0_ready = grant[0];
   assign req1_ready = grant[1];
   assign clear_busy = (state_q == ST_CLEAR_PO) || (state_q == ST_CLEAR_DO);
   assign wr_en      = wr_en_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign addr_err   = addr_err_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_address_config_arbiter.sv
module tb_address_config_arbiter;
   import address_config_pkg::*;

   localparam int AW = 10;
   localparam int DW = 36;
   localparam int OW = 1 + AW + DW + 1;

   // ---------------- clock / reset ----------------
   logic clock = 1'b0;
   logic reset_n;
   always #5 clock = ~clock;

   logic          req0_valid, req0_ready, req1_valid, req1_ready;
   logic [AW-1:0] req0_addr, req1_addr, wr_addr;
   logic [DW-1:0] req0_data, req1_data, wr_data;
   logic          clear_start, clear_busy, stall, wr_en, addr_err;
   state_t        dbg_state;

   address_config_arbiter #(
      .WRITE_ADDR_WIDTH (AW),
      .WRITE_WORD_WIDTH (DW),
      .PO_ADDR_BASE     (32'h200),
      .PO_ENTRY_COUNT   (4),
      .DO_ADDR          (32'h208)
   ) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .req0_valid  (req0_valid),
      .req0_ready  (req0_ready),
      .req0_addr   (req0_addr),
      .req0_data   (req0_data),
      .req1_valid  (req1_valid),
      .req1_ready  (req1_ready),
      .req1_addr   (req1_addr),
      .req1_data   (req1_data),
      .clear_start (clear_start),
      .clear_busy  (clear_busy),
      .stall       (stall),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .addr_err    (addr_err),
      .dbg_state   (dbg_state)
   );

   // ---------------- vector table ----------------
   typedef struct {
      logic          stall, clr;
      logic          v0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          v1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          r0, r1, busy;
      logic          we;
      logic [AW-1:0] ea;
      logic [DW-1:0] ed;
      logic          err;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic st, input logic cl,
                      input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                      input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                      input logic r0, input logic r1, input logic busy,
                      input logic we, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                      input logic err);
      vec_t v;
      v.stall = st; v.clr = cl;
      v.v0 = v0; v.a0 = a0; v.d0 = d0;
      v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.r0 = r0; v.r1 = r1; v.busy = busy;
      v.we = we; v.ea = ea; v.ed = ed; v.err = err;
      vecs.push_back(v);
   endtask

   // Idle cycle and clear-step helpers (no requests, expected write or none).
   task automatic add_idle(input logic busy);
      add(0, 0, 0, '0, '0, 0, '0, '0, 0, 0, busy, 0, '0, '0, 0);
   endtask

   task automatic add_clr(input logic st, input logic we, input logic [AW-1:0] ea);
      add(st, 0, 0, '0, '0, 0, '0, '0, 0, 0, 1, we, ea, '0, 0);
   endtask

   // ---------------- scoreboard ----------------
   logic [OW-1:0] exp_q[$];
   logic [AW-1:0] hold_addr;
   logic [DW-1:0] hold_data;
   int            n_vec = 0;
   int            n_err = 0;

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
      end
   endtask

   // Driven at a negedge; handshake checked mid-low-phase; the registered
   // result is compared at the following negedge.
   task automatic apply_vec(input vec_t v, input int idx);
      logic [OW-1:0] got;
      logic [OW-1:0] e;
      stall = v.stall; clear_start = v.clr;
      req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
      req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
      #2;
      chk($sformatf("vec%0d ready0/ready1/busy", idx),
          64'({req0_ready, req1_ready, clear_busy}), 64'({v.r0, v.r1, v.busy}));
      if (v.we) begin
         hold_addr = v.ea;
         hold_data = v.ed;
      end
      exp_q.push_back({v.we, hold_addr, hold_data, v.err});
      @(negedge clock);
      got = {wr_en, wr_addr, wr_data, addr_err};
      if (exp_q.size() == 0) begin
         n_err++;
         $display("FAIL vec%0d wr_port: got 0x%0h with empty expected queue", idx, got);
      end else begin
         e = exp_q.pop_front();
         chk($sformatf("vec%0d wr_port{en,addr,data,err}", idx), 64'(got), 64'(e));
      end
      n_vec++;
   endtask

   logic [DW-1:0] rd0, rd1;
   logic [AW-1:0] ta0, ta1;
   vec_t          tv;

   initial begin
      reset_n = 1'b0; stall = 1'b0; clear_start = 1'b0;
      req0_valid = 1'b0; req0_addr = '0; req0_data = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_data = '0;
      hold_addr = '0; hold_data = '0;

      // ---- contention: req0 wins first tie after reset, then alternates ----
      for (int i = 0; i < 4; i++) begin
         rd0 = {4'($urandom_range(0, 15)), 32'($urandom())};
         rd1 = {4'($urandom_range(0, 15)), 32'($urandom())};
         ta0 = 10'h200 + 10'(i);
         ta1 = 10'h203 - 10'(i);
         if (i % 2 == 0) add(0, 0, 1, ta0, rd0, 1, ta1, rd1, 1, 0, 0, 1, ta0, rd0, 0);
         else            add(0, 0, 1, ta0, rd0, 1, ta1, rd1, 0, 1, 0, 1, ta1, rd1, 0);
      end
      // lone req1 right after req1 was granted is still granted
      rd1 = {4'($urandom_range(0, 15)), 32'($urandom())};
      add(0, 0, 0, '0, '0, 1, 10'h202, rd1, 0, 1, 0, 1, 10'h202, rd1, 0);
      add_idle(0);
      // single write
      add(0, 0, 1, 10'h201, 36'h5, 0, '0, '0, 1, 0, 0, 1, 10'h201, 36'h5, 0);
      // DO slot via request
      add(0, 0, 1, 10'h208, 36'h987654321, 0, '0, '0, 1, 0, 0, 1, 10'h208, 36'h987654321, 0);
      // out-of-range: accepted, no write, error pulse
      add(0, 0, 0, '0, '0, 1, 10'h300, 36'h7, 0, 1, 0, 0, '0, '0, 1);
      add(0, 0, 1, 10'h204, 36'h1, 0, '0, '0, 1, 0, 0, 0, '0, '0, 1);
      add(0, 0, 0, '0, '0, 1, 10'h1ff, 36'h2, 0, 1, 0, 0, '0, '0, 1);
      // stall: nothing accepted, clear_start ignored, pointer held (last=req1)
      add(1, 1, 1, 10'h203, 36'h11, 1, 10'h200, 36'h22, 0, 0, 0, 0, '0, '0, 0);
      add(0, 0, 1, 10'h203, 36'h11, 1, 10'h200, 36'h22, 1, 0, 0, 1, 10'h203, 36'h11, 0);
      // clean clear, with competing requests held off
      add(0, 1, 1, 10'h201, 36'h44, 1, 10'h202, 36'h33, 0, 0, 0, 0, '0, '0, 0);
      add(0, 0, 1, 10'h201, 36'h44, 1, 10'h202, 36'h33, 0, 0, 1, 1, 10'h200, '0, 0);
      add(0, 1, 0, '0, '0, 0, '0, '0, 0, 0, 1, 1, 10'h201, '0, 0);
      add_clr(0, 1, 10'h202);
      add_clr(0, 1, 10'h203);
      add_clr(0, 1, 10'h208);
      // pointer survives the clear: last=req0, so req1 wins
      add(0, 0, 1, 10'h201, 36'h44, 1, 10'h202, 36'h33, 0, 1, 0, 1, 10'h202, 36'h33, 0);
      // clear with a 2-cycle stall after 0x201
      add(0, 1, 0, '0, '0, 0, '0, '0, 0, 0, 0, 0, '0, '0, 0);
      add_clr(0, 1, 10'h200);
      add_clr(0, 1, 10'h201);
      add_clr(1, 0, '0);
      add_clr(1, 0, '0);
      add_clr(0, 1, 10'h202);
      add_clr(0, 1, 10'h203);
      add_clr(0, 1, 10'h208);
      add_idle(0);

      // ---- reset state ----
      repeat (3) @(negedge clock);
      #1;
      chk("reset wr_en", 64'(wr_en), 64'(0));
      chk("reset wr_addr", 64'(wr_addr), 64'(0));
      chk("reset wr_data", 64'(wr_data), 64'(0));
      chk("reset addr_err", 64'(addr_err), 64'(0));
      chk("reset clear_busy", 64'(clear_busy), 64'(0));
      chk("reset state", 64'(dbg_state), 64'(ST_IDLE));
      @(negedge clock);
      reset_n = 1'b1;

      foreach (vecs[i]) apply_vec(vecs[i], i);

      // ---- reset during clear, after the 0x202 write ----
      tv.stall = 0; tv.clr = 1; tv.v0 = 0; tv.a0 = '0; tv.d0 = '0;
      tv.v1 = 0; tv.a1 = '0; tv.d1 = '0; tv.r0 = 0; tv.r1 = 0; tv.busy = 0;
      tv.we = 0; tv.ea = '0; tv.ed = '0; tv.err = 0;
      apply_vec(tv, 100);
      tv.clr = 0; tv.busy = 1; tv.we = 1;
      for (int k = 0; k < 3; k++) begin
         tv.ea = 10'h200 + 10'(k);
         apply_vec(tv, 101 + k);
      end
      reset_n = 1'b0;
      #1;
      chk("async reset wr_en", 64'(wr_en), 64'(0));
      chk("async reset wr_addr", 64'(wr_addr), 64'(0));
      chk("async reset wr_data", 64'(wr_data), 64'(0));
      chk("async reset addr_err", 64'(addr_err), 64'(0));
      chk("async reset clear_busy", 64'(clear_busy), 64'(0));
      chk("async reset state", 64'(dbg_state), 64'(ST_IDLE));
      repeat (2) @(negedge clock);
      reset_n = 1'b1;
      exp_q.delete();
      hold_addr = '0;
      hold_data = '0;
      tv.busy = 0; tv.we = 0; tv.ea = '0;
      for (int k = 0; k < 3; k++) apply_vec(tv, 110 + k);
      chk("post-reset state", 64'(dbg_state), 64'(ST_IDLE));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
